// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: packer FSM states and
// a helper that sizes the packed-word lane count.
package fifo_pkg;

  // Packer FSM: FILL gathers lanes from the FIFO, HOLD presents a packed word.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Width needed to express a lane count of 0..ratio.
  function automatic int count_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_packer.sv
// Drains narrow words from a show-ahead FIFO and packs RATIO of them into one
// wide word, lane 0 in the LSBs. A flush emits a partially filled word; unused
// lanes read 0.
//
// Handshake: out_data/out_count are valid while out_valid is high and stay
// stable until the edge where out_valid && out_ready, which transfers the word.
// pop_enable is a combinational request; the FIFO head is consumed on every
// rising edge where pop_enable is high.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int RATIO = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [$clog2(DEPTH):0]              item_count,
  input  logic [WIDTH-1:0]                    pop_data,
  output logic                                pop_enable,
  input  logic                                flush,
  output logic [WIDTH*RATIO-1:0]              out_data,
  output logic [count_width(RATIO)-1:0]       out_count,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int CW = count_width(RATIO);
  localparam int LW = $clog2(RATIO);

  pack_state_e   state;
  logic [LW-1:0] lane;

  // Pop whenever filling and the FIFO has data; never while in reset.
  always_comb begin
    pop_enable = rst_n && (state == FILL) && (item_count != '0);
  end

  // Lane gathering, word completion / flush, and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      lane      <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop_enable) begin
            for (int i = 0; i < RATIO; i++) begin
              if (lane == LW'(i)) begin
                out_data[i*WIDTH +: WIDTH] <= pop_data;
              end
            end
          end
          // A completing pop wins over a simultaneous flush: full word.
          if (pop_enable && (lane == LW'(RATIO - 1))) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= CW'(RATIO);
          end else if (flush && ((lane != '0) || pop_enable)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= CW'(lane) + CW'(pop_enable);
          end else if (pop_enable) begin
            lane <= lane + 1'b1;
          end
        end
        HOLD: begin
          // Word accepted: clear lanes so a later partial word reads 0 above its fill.
          if (out_ready) begin
            state     <= FILL;
            lane      <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer with WIDTH=2, DEPTH=4, RATIO=4. The upstream FIFO is a
// queue inside the bench; a queue-based packing model predicts every word.
module tb_fifo_packer;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int RATIO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] item_count;
  logic [1:0] pop_data;
  logic       pop_enable;
  logic       flush;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       out_valid;
  logic       out_ready;

  fifo_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .item_count (item_count),
    .pop_data   (pop_data),
    .pop_enable (pop_enable),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         push;
    logic [1:0] pval;
    bit         fl;
    bit         rdy;
    bit         chk;
    bit         e_valid;
    logic [7:0] e_data;
    logic [2:0] e_count;
    bit         e_pop;
  } vec_t;

  vec_t vecs[19];
  vec_t none;

  logic [1:0] fifo_q[$];
  logic [1:0] src_q[$];
  logic [1:0] pend[$];
  logic [7:0] exp_q[$];
  logic [2:0] expc_q[$];
  bit         waiting;
  int         n_words = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_fifo();
    item_count = 3'(fifo_q.size());
    pop_data   = (fifo_q.size() != 0) ? fifo_q[0] : 2'b00;
  endtask

  // Model: pack the gathered words into an expected output word.
  task automatic emit();
    logic [7:0] data;
    data = '0;
    for (int i = 0; i < pend.size(); i++) data = data | (8'(pend[i]) << (2 * i));
    exp_q.push_back(data);
    expc_q.push_back(3'(pend.size()));
    pend.delete();
    waiting = 1'b1;
  endtask

  // Driver: one clock cycle. Entered and left 1 time unit after a rising edge.
  task automatic tick(input bit fl, input bit rdy, input bit use_row, input vec_t row, input int idx);
    bit exp_pop, dut_pop, do_push;
    flush     = fl;
    out_ready = rdy;
    @(negedge clk);
    exp_pop = !waiting && (fifo_q.size() != 0);
    check("pop_enable", pop_enable, exp_pop);
    check("out_valid", out_valid, waiting);
    if (waiting) begin
      check("out_data", out_data, exp_q[0]);
      check("out_count", out_count, expc_q[0]);
    end
    if (use_row && row.chk) begin
      check($sformatf("row%0d_valid", idx), out_valid, row.e_valid);
      check($sformatf("row%0d_pop", idx), pop_enable, row.e_pop);
      if (row.e_valid) begin
        check($sformatf("row%0d_data", idx), out_data, row.e_data);
        check($sformatf("row%0d_count", idx), out_count, row.e_count);
      end
    end
    dut_pop = pop_enable;
    do_push = (src_q.size() != 0) && (fifo_q.size() < DEPTH);
    if (waiting) begin
      if (rdy) begin
        waiting = 1'b0;
        exp_q.delete(0);
        expc_q.delete(0);
        n_words++;
      end
    end else if (exp_pop) begin
      pend.push_back(fifo_q[0]);
      if (pend.size() == RATIO) emit();
      else if (fl) emit();
    end else if (fl && pend.size() != 0) begin
      emit();
    end
    @(posedge clk);
    #1;
    if (dut_pop && fifo_q.size() != 0) fifo_q.delete(0);
    if (do_push) begin
      fifo_q.push_back(src_q[0]);
      src_q.delete(0);
    end
    flush = 1'b0;
    drive_fifo();
  endtask

  initial begin
    int n0;
    int vc;
    bit seen;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    waiting   = 1'b0;
    none      = '{0, 2'b00, 0, 0, 0, 0, 8'h00, 3'd0, 0};
    drive_fifo();

    // Full word 01,11,10,00 -> 2D
    vecs[0]  = '{1, 2'b01, 0, 1, 1, 0, 8'h00, 3'd0, 0};
    vecs[1]  = '{1, 2'b11, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[2]  = '{1, 2'b10, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[3]  = '{1, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[4]  = '{0, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[5]  = '{0, 2'b00, 0, 1, 1, 1, 8'h2D, 3'd4, 0};
    vecs[6]  = '{0, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 0};
    // Partial flush 11,10 -> 0B, count 2
    vecs[7]  = '{1, 2'b11, 0, 1, 1, 0, 8'h00, 3'd0, 0};
    vecs[8]  = '{1, 2'b10, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[9]  = '{0, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[10] = '{0, 2'b00, 1, 1, 1, 0, 8'h00, 3'd0, 0};
    vecs[11] = '{0, 2'b00, 0, 1, 1, 1, 8'h0B, 3'd2, 0};
    vecs[12] = '{0, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 0};
    // Flush together with the pop of 01 at lane 2 -> 1E, count 3
    vecs[13] = '{1, 2'b10, 0, 1, 1, 0, 8'h00, 3'd0, 0};
    vecs[14] = '{1, 2'b11, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[15] = '{1, 2'b01, 0, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[16] = '{0, 2'b00, 1, 1, 1, 0, 8'h00, 3'd0, 1};
    vecs[17] = '{0, 2'b00, 0, 1, 1, 1, 8'h1E, 3'd3, 0};
    vecs[18] = '{0, 2'b00, 0, 1, 1, 0, 8'h00, 3'd0, 0};

    // Reset state, with data present in the FIFO
    #12;
    fifo_q.push_back(2'b11);
    drive_fifo();
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_out_count", out_count, 3'd0);
    check("reset_pop_enable", pop_enable, 1'b0);
    fifo_q.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven directed vectors
    foreach (vecs[i]) begin
      if (vecs[i].push) src_q.push_back(vecs[i].pval);
      tick(vecs[i].fl, vecs[i].rdy, 1'b1, vecs[i], i);
    end

    // Backpressure: first word 3,2,1,0 held while 8 more words back up
    n0 = n_words;
    src_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 24; i++) tick(1'b0, 1'b0, 1'b0, none, 0);
    check("bp_fifo_full", item_count, 3'd4);
    check("bp_src_left", src_q.size(), 4);
    check("bp_hold_data", out_data, 8'h1B);
    check("bp_hold_pop", pop_enable, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ((n_words - n0) == 3 && src_q.size() == 0 && fifo_q.size() == 0 && !waiting) break;
      tick(1'b0, 1'b1, 1'b0, none, 0);
    end
    check("bp_words_out", n_words - n0, 3);

    // Empty FIFO with an idle flush at lane 0
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i == 5, 1'b1, 1'b0, none, 0);
      if (out_valid || pop_enable) vc++;
    end
    check("idle_activity", vc, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1 && src_q.size() < 4) src_q.push_back(2'($urandom_range(0, 3)));
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'b0, none, 0);
    end
    for (int i = 0; i < 60; i++) tick((i % 8) == 0, 1'b1, 1'b0, none, 0);

    // Reset mid-word after two pops
    src_q.push_back(2'b01);
    src_q.push_back(2'b10);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, none, 0);
    #3;
    rst_n = 1'b0;
    fifo_q = '{2'b11};
    drive_fifo();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_out_count", out_count, 3'd0);
    check("midrst_pop_enable", pop_enable, 1'b0);
    fifo_q.delete();
    src_q.delete();
    pend.delete();
    exp_q.delete();
    expc_q.delete();
    waiting = 1'b0;
    drive_fifo();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_q = '{2'b10, 2'b01, 2'b11, 2'b00};
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, none, 0);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("post_rst_word_seen", seen, 1'b1);
    check("post_rst_data", out_data, 8'h36);
    check("post_rst_count", out_count, 3'd4);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, none, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
